subtract_core: RTL and testbench
================================

Name: subtract_core

Overview:
- Parameterised unsigned subtractor used by the RSA datapath for modular-reduction compare/subtract steps.
- Computes d = a − b modulo 2^WIDTH and a flag aBigB indicating a ≥ b (no final borrow).
- Built as a ripple-borrow chain of 1-bit full-subtractor cells.
- Outputs are registered behind a single-cycle valid pipeline stage.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range ≥ 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a and b for capture this cycle.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- d  output  WIDTH  registered difference, a − b mod 2^WIDTH.
- aBigB  output  1  registered flag: 1 when a ≥ b, 0 when a < b.
- out_valid  output  1  high for one cycle when d and aBigB hold a new result.

Behaviour:
- Reset: asserting rst immediately, independent of clk, forces d = 0, aBigB = 0 and out_valid = 0. These values hold while rst is high.
- Combinational core:
  - bit i: diff_i = a_i ^ b_i ^ borrow_i.
  - borrow_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i).
  - borrow_0 = 0.
- Flag: aBigB_next = ~borrow_WIDTH. Equality (a == b) gives aBigB = 1 and d = 0.
- Wrap-around: when a < b, d is the two's-complement wrap, i.e. 2^WIDTH + a − b. No saturation.
- Latency: exactly 1 cycle.
  - On a rising edge with in_valid = 1, register d, aBigB and out_valid = 1.
  - On a rising edge with in_valid = 0, set out_valid = 0 and hold d and aBigB unchanged.
- Throughput: one operation per cycle. Back-to-back in_valid pulses produce back-to-back out_valid pulses.
- Reset mid-operation: an operation captured in the same cycle that rst asserts is discarded. The first valid result after rst deasserts comes from the first in_valid sampled on a rising edge with rst low.
- Inputs: a and b are don't-care when in_valid = 0, and X on them must not propagate into registers.
- No other state. No back-pressure.

Decomposition:
- Shared package sub_pkg holds:
  - the default width constant SUB_WIDTH = 4;
  - a helper typedef for a WIDTH-bit unsigned word.
- One natural sub-module: full_subtractor (inputs a, b, bin; outputs diff, bout). It is instantiated WIDTH times via a generate loop.
- subtract_core holds the generate chain plus the output register stage.

Test Plan (WIDTH = 4; each result checked one cycle after the in_valid edge):
- Reset: hold rst = 1 with random a and b, then pulse clk → d = 0, aBigB = 0, out_valid = 0. Assert rst asynchronously between edges → outputs clear immediately.
- Borrow case: a = 4'b1000, b = 4'b1101 → d = 4'b1011, aBigB = 0. Then a = 4'b0000, b = 4'b1011 → d = 4'b0101, aBigB = 0.
- No-borrow case: a = 4'b1101, b = 4'b1100 → d = 4'b0001, aBigB = 1. Then a = 4'b1100, b = 4'b1001 → d = 4'b0011, aBigB = 1. Then a = 4'b0011, b = 4'b0001 → d = 4'b0010, aBigB = 1.
- Boundaries:
  - a = b = 4'b0111 → d = 0, aBigB = 1.
  - a = 4'b0000, b = 4'b0001 → d = 4'b1111, aBigB = 0.
  - a = 4'b1111, b = 4'b0000 → d = 4'b1111, aBigB = 1.
- Handshake: drive in_valid high for 3 consecutive cycles, then low for 2 → out_valid high for exactly 3 cycles, lagging by 1, and d holds its last value while out_valid = 0.
- Exhaustive: sweep all 256 (a, b) pairs back-to-back → every d equals (a − b) & 4'hF and every aBigB equals (a ≥ b).

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants and types for the unsigned subtractor used in the RSA datapath.
package sub_pkg;

   localparam int SUB_WIDTH = 4;

   typedef logic [SUB_WIDTH-1:0] sub_word_t;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   // Borrow when b exceeds a, or when they match and a borrow ripples in.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/subtract_core.sv
// Unsigned ripple-borrow subtractor with one registered output stage.
// d = a - b mod 2^WIDTH; aBigB = 1 when a >= b (no final borrow).
module subtract_core
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] d,
   output logic             aBigB,
   output logic             out_valid
);

   logic [WIDTH:0]   borrow_p0;
   logic [WIDTH-1:0] diff_p0;

   logic [WIDTH-1:0] d_p1;
   logic             abigb_p1;
   logic             vld_p1;

   assign borrow_p0[0] = 1'b0;

   // ---- stage p0: combinational borrow chain ----
   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_subtractor u_fs (
         .a    (a[i]),
         .b    (b[i]),
         .bin  (borrow_p0[i]),
         .diff (diff_p0[i]),
         .bout (borrow_p0[i+1])
      );
   end

   // ---- stage p1: capture result only on valid so idle/X inputs never load ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_p1     <= '0;
         abigb_p1 <= 1'b0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            d_p1     <= diff_p0;
            abigb_p1 <= ~borrow_p0[WIDTH];
         end
      end
   end

   assign d         = d_p1;
   assign aBigB     = abigb_p1;
   assign out_valid = vld_p1;

endmodule : subtract_core

// File: tb/tb_subtract_core.sv
// Self-checking bench for subtract_core (WIDTH = 4): arithmetic model plus directed vectors.
module tb_subtract_core;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] d;
   logic         aBigB;
   logic         out_valid;

   int checks = 0;
   int errors = 0;

   // reference model state: what the registered outputs must hold
   logic [W-1:0] m_d = '0;
   logic         m_f = 1'b0;
   logic         m_v = 1'b0;

   subtract_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .d         (d),
      .aBigB     (aBigB),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: plain modular subtraction and magnitude compare, one cycle late
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_d <= '0;
         m_f <= 1'b0;
         m_v <= 1'b0;
      end else begin
         m_v <= in_valid;
         if (in_valid) begin
            m_d <= W'((32'(a) + 32'(1 << W) - 32'(b)) % (1 << W));
            m_f <= (a >= b);
         end
      end
   end

   // continuous comparison of DUT against model, away from the active edge
   always @(negedge clk) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(m_v));
      chk("cmp_d", 32'(d), 32'(m_d));
      chk("cmp_aBigB", 32'(aBigB), 32'(m_f));
   end

   // one operation with literal expectation checked just after the capturing edge
   task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input logic [W-1:0] ed, input logic ef, input string name);
      @(negedge clk);
      a = xa;
      b = xb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({name, "_d"}, 32'(d), 32'(ed));
      chk({name, "_flag"}, 32'(aBigB), 32'(ef));
      chk({name, "_vld"}, 32'(out_valid), 32'd1);
   endtask

   task automatic idle(input logic [W-1:0] hold_d, input logic hold_f, input string name);
      @(negedge clk);
      a = 'x;
      b = 'x;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk({name, "_vld"}, 32'(out_valid), 32'd0);
      chk({name, "_hold_d"}, 32'(d), 32'(hold_d));
      chk({name, "_hold_flag"}, 32'(aBigB), 32'(hold_f));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset held with random operands and valid asserted
      rst = 1'b1;
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_d", 32'(d), 32'd0);
      chk("rst_flag", 32'(aBigB), 32'd0);
      chk("rst_vld", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;

      // asynchronous reset between edges clears a live result immediately
      op(4'b1000, 4'b1101, 4'b1011, 1'b0, "pre_async");
      #2;
      rst = 1'b1;
      #1;
      chk("async_d", 32'(d), 32'd0);
      chk("async_flag", 32'(aBigB), 32'd0);
      chk("async_vld", 32'(out_valid), 32'd0);
      // operation offered while in reset must be discarded
      @(negedge clk);
      a = 4'b0001;
      b = 4'b0000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("in_rst_vld", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_vld", 32'(out_valid), 32'd0);
      chk("post_rst_d", 32'(d), 32'd0);

      // borrow cases
      op(4'b1000, 4'b1101, 4'b1011, 1'b0, "borrow1");
      op(4'b0000, 4'b1011, 4'b0101, 1'b0, "borrow2");
      // no-borrow cases
      op(4'b1101, 4'b1100, 4'b0001, 1'b1, "nob1");
      op(4'b1100, 4'b1001, 4'b0011, 1'b1, "nob2");
      op(4'b0011, 4'b0001, 4'b0010, 1'b1, "nob3");
      // boundaries
      op(4'b0111, 4'b0111, 4'b0000, 1'b1, "equal");
      op(4'b0000, 4'b0001, 4'b1111, 1'b0, "wrap_min");
      op(4'b1111, 4'b0000, 4'b1111, 1'b1, "max_minus_zero");

      // handshake: three back-to-back, then two idle cycles holding the last result
      op(4'b0101, 4'b0010, 4'b0011, 1'b1, "hs1");
      op(4'b0010, 4'b0101, 4'b1101, 1'b0, "hs2");
      op(4'b1010, 4'b0110, 4'b0100, 1'b1, "hs3");
      idle(4'b0100, 1'b1, "hs_idle1");
      idle(4'b0100, 1'b1, "hs_idle2");

      // exhaustive back-to-back sweep
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            op(W'(i), W'(j), W'((i - j + 16) % 16), (i >= j), "sweep");
         end
      end

      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_subtract_core
